// File: rtl/register_write_stage_pkg.sv
// Shared constants and FSM encoding for the register-file write stage.
package register_write_stage_pkg;

    localparam int NUM_REGS   = 8;
    localparam int ADDR_W     = 3;
    localparam int DATA_W_DEF = 32;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_e;

endpackage

// File: rtl/register_write_stage_decoder.sv
// 3-to-8 one-hot decoder; used for both the write address and the clear counter.
module write_decoder_3to8
    import register_write_stage_pkg::*;
(
    input  logic [ADDR_W-1:0]   addr,
    input  logic                en,
    output logic [NUM_REGS-1:0] onehot
);

    always_comb begin
        onehot = '0;
        if (en) begin
            onehot[addr] = 1'b1;
        end
    end

endmodule

// File: rtl/register_write_stage.sv
// Eight-entry register file write side: handshaked single writes plus a
// progressive one-register-per-cycle clear sequence.
module register_write_stage
    import register_write_stage_pkg::*;
#(
    parameter int DATA_W    = DATA_W_DEF,
    parameter int ZERO_REG0 = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [2:0]        wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              clr_start,
    output logic              clr_busy,
    output logic [DATA_W-1:0] to_reg0,
    output logic [DATA_W-1:0] to_reg1,
    output logic [DATA_W-1:0] to_reg2,
    output logic [DATA_W-1:0] to_reg3,
    output logic [DATA_W-1:0] to_reg4,
    output logic [DATA_W-1:0] to_reg5,
    output logic [DATA_W-1:0] to_reg6,
    output logic [DATA_W-1:0] to_reg7
);

    state_e                          state_q, state_d;
    logic [ADDR_W-1:0]               cnt_q, cnt_d;
    logic [NUM_REGS-1:0][DATA_W-1:0] regs_q, regs_d;

    logic                wr_fire;
    logic                clearing;
    logic [NUM_REGS-1:0] wr_en;
    logic [NUM_REGS-1:0] clr_en;
    logic [NUM_REGS-1:0] reg_en;
    logic [DATA_W-1:0]   reg_wdata;

    // Handshake flags come from registered state only.
    assign clearing = (state_q == ST_CLEAR);
    assign wr_ready = !clearing;
    assign clr_busy = clearing;
    assign wr_fire  = wr_valid && wr_ready;

    write_decoder_3to8 u_wr_dec (
        .addr   (wr_addr),
        .en     (wr_fire),
        .onehot (wr_en)
    );

    write_decoder_3to8 u_clr_dec (
        .addr   (cnt_q),
        .en     (clearing),
        .onehot (clr_en)
    );

    // The two enables are exclusive by state, so a single data mux suffices.
    assign reg_en    = wr_en | clr_en;
    assign reg_wdata = clearing ? '0 : wr_data;

    always_comb begin
        regs_d = regs_q;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (reg_en[i]) begin
                regs_d[i] = reg_wdata;
            end
        end
        if (ZERO_REG0 != 0) begin
            regs_d[0] = '0;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            ST_IDLE: begin
                if (clr_start) begin
                    state_d = ST_CLEAR;
                    cnt_d   = '0;
                end
            end
            ST_CLEAR: begin
                // Counter wraps 7->0 exactly as the sequence returns to IDLE.
                cnt_d = cnt_q + 3'd1;
                if (cnt_q == 3'd7) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            regs_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            regs_q  <= regs_d;
        end
    end

    assign to_reg0 = (ZERO_REG0 != 0) ? '0 : regs_q[0];
    assign to_reg1 = regs_q[1];
    assign to_reg2 = regs_q[2];
    assign to_reg3 = regs_q[3];
    assign to_reg4 = regs_q[4];
    assign to_reg5 = regs_q[5];
    assign to_reg6 = regs_q[6];
    assign to_reg7 = regs_q[7];

endmodule

// File: tb/tb_register_write_stage.sv
// Bench for register_write_stage: two instances (ZERO_REG0=0 and 1) share
// stimulus and are checked against an array-based reference model.
module tb_register_write_stage;

    logic        clk;
    logic        reset;
    logic        wr_valid;
    logic [2:0]  wr_addr;
    logic [31:0] wr_data;
    logic        clr_start;

    logic        rdy0, busy0, rdy1, busy1;
    logic [31:0] a0, a1, a2, a3, a4, a5, a6, a7;
    logic [31:0] b0, b1, b2, b3, b4, b5, b6, b7;
    logic [31:0] oa [8];
    logic [31:0] ob [8];

    int n_assert;
    int n_fail;

    // Reference model state
    logic [31:0] ma [8];
    logic [31:0] mb [8];
    bit          m_busy;
    int          m_idx;

    register_write_stage #(.DATA_W(32), .ZERO_REG0(0)) u_dut0 (
        .clk(clk), .reset(reset), .wr_valid(wr_valid), .wr_ready(rdy0),
        .wr_addr(wr_addr), .wr_data(wr_data), .clr_start(clr_start), .clr_busy(busy0),
        .to_reg0(a0), .to_reg1(a1), .to_reg2(a2), .to_reg3(a3),
        .to_reg4(a4), .to_reg5(a5), .to_reg6(a6), .to_reg7(a7)
    );

    register_write_stage #(.DATA_W(32), .ZERO_REG0(1)) u_dut1 (
        .clk(clk), .reset(reset), .wr_valid(wr_valid), .wr_ready(rdy1),
        .wr_addr(wr_addr), .wr_data(wr_data), .clr_start(clr_start), .clr_busy(busy1),
        .to_reg0(b0), .to_reg1(b1), .to_reg2(b2), .to_reg3(b3),
        .to_reg4(b4), .to_reg5(b5), .to_reg6(b6), .to_reg7(b7)
    );

    always_comb begin
        oa[0] = a0; oa[1] = a1; oa[2] = a2; oa[3] = a3;
        oa[4] = a4; oa[5] = a5; oa[6] = a6; oa[7] = a7;
        ob[0] = b0; ob[1] = b1; ob[2] = b2; ob[3] = b3;
        ob[4] = b4; ob[5] = b5; ob[6] = b6; ob[7] = b7;
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Model of one clock edge, written from the behavioural rules.
    task automatic model_edge();
        if (reset) begin
            for (int i = 0; i < 8; i++) begin ma[i] = 0; mb[i] = 0; end
            m_busy = 0;
            m_idx  = 0;
        end else if (m_busy) begin
            ma[m_idx] = 0;
            mb[m_idx] = 0;
            m_idx++;
            if (m_idx == 8) begin m_busy = 0; m_idx = 0; end
        end else begin
            if (wr_valid) begin
                ma[wr_addr] = wr_data;
                if (wr_addr != 0) mb[wr_addr] = wr_data;
            end
            if (clr_start) begin m_busy = 1; m_idx = 0; end
        end
    endtask

    task automatic check_all(input string tag);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("%s.z0.reg%0d", tag, i), oa[i], ma[i]);
            chk($sformatf("%s.z1.reg%0d", tag, i), ob[i], mb[i]);
        end
        chk({tag, ".z0.wr_ready"}, {31'd0, rdy0},  {31'd0, !m_busy});
        chk({tag, ".z0.clr_busy"}, {31'd0, busy0}, {31'd0, m_busy});
        chk({tag, ".z1.wr_ready"}, {31'd0, rdy1},  {31'd0, !m_busy});
        chk({tag, ".z1.clr_busy"}, {31'd0, busy1}, {31'd0, m_busy});
    endtask

    task automatic step(input string tag, input logic rst, input logic v, input logic [2:0] ad,
                        input logic [31:0] d, input logic cs);
        reset     = rst;
        wr_valid  = v;
        wr_addr   = ad;
        wr_data   = d;
        clr_start = cs;
        @(posedge clk);
        model_edge();
        #1;
        check_all(tag);
    endtask

    int busy_cnt;

    initial begin
        n_assert = 0;
        n_fail   = 0;
        m_busy   = 0;
        m_idx    = 0;
        for (int i = 0; i < 8; i++) begin ma[i] = 'x; mb[i] = 'x; end
        reset = 1; wr_valid = 0; wr_addr = 0; wr_data = 0; clr_start = 0;
        #1;

        // Reset, then idle
        step("rst", 1, 0, 0, 0, 0);
        step("rst2", 1, 0, 0, 0, 0);
        step("idle", 0, 0, 3'd5, 32'hCAFEF00D, 0);
        chk("reset.reg3_zero", a3, 32'h0);

        // Back-to-back writes
        step("wr3", 0, 1, 3'd3, 32'hDEADBEEF, 0);
        chk("wr3.latency1", a3, 32'hDEADBEEF);
        chk("wr3.reg7_still0", a7, 32'h0);
        step("wr7", 0, 1, 3'd7, 32'h12345678, 0);
        chk("wr7.value", a7, 32'h12345678);
        step("wr_idle", 0, 0, 3'd3, 32'h0, 0);

        // Same address twice in a row: second value wins
        step("wr1a", 0, 1, 3'd1, 32'h11111111, 0);
        step("wr1b", 0, 1, 3'd1, 32'h22222222, 0);
        chk("wr1.second_wins", a1, 32'h22222222);

        // Address 0 with and without ZERO_REG0
        step("wr0", 0, 1, 3'd0, 32'hFFFFFFFF, 0);
        chk("wr0.z0", a0, 32'hFFFFFFFF);
        chk("wr0.z1_stays0", b0, 32'h0);

        // Fill then clear, with a write held pending through CLEAR
        for (int i = 0; i < 8; i++)
            step("fill", 0, 1, i[2:0], 32'hA5A5A5A0 + i, 0);
        step("clr_go", 0, 0, 0, 0, 1);
        busy_cnt = 0;
        if (busy0) busy_cnt++;
        for (int k = 0; k < 11; k++) begin
            step("clr_hold", 0, 1, 3'd2, 32'h55, 0);
            if (busy0) busy_cnt++;
        end
        chk("clr.busy_cycles", busy_cnt, 8);
        chk("clr.held_write", a2, 32'h55);
        chk("clr.reg7_zero", a7, 32'h0);
        step("clr_idle", 0, 0, 0, 0, 0);

        // Write + clr_start together, then a second clr_start mid-CLEAR
        for (int i = 0; i < 8; i++)
            step("fill2", 0, 1, i[2:0], 32'h0F000000 + i, 0);
        step("wr5_clr", 0, 1, 3'd5, 32'h77, 1);
        chk("wr5.accepted", a5, 32'h77);
        busy_cnt = 1;
        for (int k = 0; k < 11; k++) begin
            step("clr2", 0, 0, 0, 0, (k == 2));
            if (busy0) busy_cnt++;
            if (k == 4) chk("clr2.reg5_before", a5, 32'h77);
            if (k == 5) chk("clr2.reg5_cleared", a5, 32'h0);
        end
        chk("clr2.busy_cycles", busy_cnt, 8);

        // Reset in the middle of CLEAR
        for (int i = 0; i < 8; i++)
            step("fill3", 0, 1, i[2:0], 32'h3C000000 + i, 0);
        step("clr3_go", 0, 0, 0, 0, 1);
        step("clr3_c1", 0, 0, 0, 0, 0);
        step("clr3_c2", 0, 0, 0, 0, 0);
        chk("clr3.reg4_live", a4, 32'h3C000004);
        step("clr3_rst", 1, 0, 0, 0, 0);
        chk("clr3.reg7_zero", a7, 32'h0);
        chk("clr3.busy_low", {31'd0, busy0}, 32'd0);
        step("clr3_after", 0, 0, 0, 0, 0);

        // Randomized traffic against the model
        for (int k = 0; k < 300; k++) begin
            step("rand", ($urandom_range(0, 99) < 2), ($urandom_range(0, 99) < 70),
                 3'($urandom_range(0, 7)), $urandom, ($urandom_range(0, 99) < 8));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
